// File: rtl/qadd_pipe.sv
// qadd_pipe: two-stage pipelined sign-magnitude fixed-point adder/subtractor.
// Optional macro QADD_SAT_EN saturates same-sign overflow instead of wrapping.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake for op, a, b
//   op                0: c = a + b, 1: c = a - b (all lanes)
//   a, b              LANES packed sign-magnitude N-bit operands
//   out_valid/out_ready output handshake for c, ovr
//   c                 LANES packed sign-magnitude results
//   ovr               per-lane overflow of the presented result
//   ovr_sticky        per-lane OR of ovr over transferred results
//   clr_sticky        clears ovr_sticky on the next edge
module qadd_pipe #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [LANES*N-1:0] a,
  input  logic [LANES*N-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] c,
  output logic [LANES-1:0]   ovr,
  output logic [LANES-1:0]   ovr_sticky,
  input  logic               clr_sticky
);

  localparam int W = LANES * N;

  // Binary point must leave at least one integer bit.
  if (Q >= N - 1) begin : g_bad_q
    $error("qadd_pipe: Q must be less than N-1");
  end

  // Stage 1 state: operands, b already carries its effective sign.
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;

  // Stage 2 state: results.
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     c_q, c_d;
  logic [LANES-1:0] ovr_q, ovr_d;
  logic [LANES-1:0] sticky_q, sticky_d;

  // Handshake.
  logic s2_load;
  logic in_xfer;
  logic out_xfer;

  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_valid_q & out_ready;

  // One lane of arithmetic; returns {ovr, sign, magnitude}.
  function automatic logic [N:0] lane_add(
    input logic [N-1:0] x,
    input logic [N-1:0] y
  );
    logic [N-2:0] ma;
    logic [N-2:0] mb;
    logic [N-2:0] mag;
    logic [N-1:0] sum;
    logic         sgn;
    logic         of;
    ma  = x[N-2:0];
    mb  = y[N-2:0];
    sum = {1'b0, ma} + {1'b0, mb};
    if (x[N-1] == y[N-1]) begin
      of  = sum[N-1];
      sgn = x[N-1];
`ifdef QADD_SAT_EN
      mag = of ? '1 : sum[N-2:0];
`else
      mag = sum[N-2:0];
`endif
    end else if (ma >= mb) begin
      of  = 1'b0;
      sgn = x[N-1];
      mag = ma - mb;
    end else begin
      of  = 1'b0;
      sgn = y[N-1];
      mag = mb - ma;
    end
    // No negative zero leaves the block.
    if (mag == '0) begin
      sgn = 1'b0;
    end
    return {of, sgn, mag};
  endfunction

  // Stage 1 next state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      for (int k = 0; k < LANES; k++) begin
        s1_b_d[k*N +: N] = {b[k*N+N-1] ^ op, b[k*N +: N-1]};
      end
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state.
  always_comb begin
    logic [N:0] r;
    r          = '0;
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    ovr_d      = ovr_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        r                = lane_add(s1_a_q[k*N +: N], s1_b_q[k*N +: N]);
        c_d[k*N +: N]    = r[N-1:0];
        ovr_d[k]         = r[N];
      end
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Sticky overflow: a setting transfer beats a same-cycle clear.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (out_xfer) begin
      sticky_d = sticky_d | ovr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      ovr_q      <= '0;
      sticky_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
      ovr_q      <= ovr_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign c          = c_q;
  assign ovr        = ovr_q;
  assign ovr_sticky = sticky_q;

endmodule

// File: tb/tb_qadd_pipe.sv
// tb_qadd_pipe: scoreboard bench for qadd_pipe, N=32, Q=15, LANES=4.
// Driver pushes expected results; negedge monitor pops and compares.
module tb_qadd_pipe;

  localparam int N = 32;
  localparam int L = 4;
  localparam int W = N * L;

  typedef struct packed {
    logic [L-1:0] o;
    logic [W-1:0] c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] c;
  logic [L-1:0] ovr;
  logic [L-1:0] ovr_sticky;
  logic         clr_sticky = 1'b0;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  qadd_pipe #(.Q(15), .N(N), .LANES(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovr(ovr), .ovr_sticky(ovr_sticky),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [N-1:0] x);
    return {L{x}};
  endfunction

  // Drive one transaction; push its expectation when it is accepted.
  task automatic send(input logic o, input logic [W-1:0] xa,
                      input logic [W-1:0] xb, input logic [W-1:0] ec,
                      input logic [L-1:0] eo);
    int n;
    exp_t e;
    op       = o;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready stuck at %b want 1", in_ready);
      $fatal(1, "input handshake timeout");
    end
    e.c = ec;
    e.o = eo;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got c=%h ovr=%b want none", c, ovr);
      end else begin
        if (c !== sb_q[0].c || ovr !== sb_q[0].o) begin
          n_fail++;
          $display("FAIL result: got c=%h ovr=%b want c=%h ovr=%b",
                   c, ovr, sb_q[0].c, sb_q[0].o);
        end
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  logic [N-1:0] sat_or_wrap;
  logic [N-1:0] neg_ovf;
  logic [W-1:0] sa;
  logic [W-1:0] sbv;
  logic [W-1:0] sc;

  initial begin
`ifdef QADD_SAT_EN
    sat_or_wrap = 32'h7FFFFFFF;
    neg_ovf     = 32'hFFFFFFFF;
`else
    sat_or_wrap = 32'h00000000;
    neg_ovf     = 32'h00000000;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_c", c, '0);
    chk("rst_ovr", W'(ovr), '0);
    chk("rst_sticky", W'(ovr_sticky), '0);
    @(posedge clk);
    #1;

    // 1.0 + 2.5 with exact latency check.
    send(0, rep(32'h00008000), rep(32'h00014000), rep(32'h0001C000), '0);
    @(negedge clk);
    chk("lat_cycle1", W'(out_valid), '0);
    @(negedge clk);
    chk("lat_cycle2", W'(out_valid), W'(1));
    @(posedge clk);
    #1;

    send(1, rep(32'h00008000), rep(32'h00014000), rep(32'h8000C000), '0);
    send(1, rep(32'h00004000), rep(32'h00004000), rep(32'h00000000), '0);
    send(0, rep(32'h80000000), rep(32'h00000000), rep(32'h00000000), '0);
    send(0, rep(32'h80000001), rep(32'h80000002), rep(32'h80000003), '0);
    send(0, rep(32'h80000000), rep(32'h80000000), rep(32'h00000000), '0);
    send(0, rep(32'hFFFFFFFF), rep(32'h80000001), rep(neg_ovf), '1);
    repeat (4) @(posedge clk);
    #1;

    // Overflow sets sticky.
    send(0, rep(32'h7FFFFFFF), rep(32'h00000001), rep(sat_or_wrap), '1);
    repeat (2) @(posedge clk);
    #1;
    chk("sticky_set", W'(ovr_sticky), W'(4'hF));

    // Reset with both stages full and a stalled output.
    out_ready = 1'b0;
    send(0, rep(32'h00000001), rep(32'h00000001), rep(32'h00000002), '0);
    send(0, rep(32'h00000003), rep(32'h00000001), rep(32'h00000004), '0);
    chk("pre_rst_valid", W'(out_valid), W'(1));
    chk("pre_rst_ready", W'(in_ready), '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    chk("mid_rst_valid", W'(out_valid), '0);
    chk("mid_rst_sticky", W'(ovr_sticky), '0);
    chk("mid_rst_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Clear after an overflow.
    send(0, rep(32'h7FFFFFFF), rep(32'h00000001), rep(sat_or_wrap), '1);
    repeat (2) @(posedge clk);
    #1;
    chk("sticky_again", W'(ovr_sticky), W'(4'hF));
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_clr", W'(ovr_sticky), '0);

    // Set beats clear in the same cycle.
    send(0, rep(32'h7FFFFFFF), rep(32'h00000001), rep(sat_or_wrap), '1);
    @(posedge clk);
    #1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_set_wins", W'(ovr_sticky), W'(4'hF));
    repeat (3) @(posedge clk);
    #1;

    // Six back-to-back items, output stalled five cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          for (int k = 0; k < L; k++) begin
            sa[k*N +: N]  = N'(k + 1 + i * 16);
            sbv[k*N +: N] = N'(i * 256);
            sc[k*N +: N]  = N'(k + 1 + i * 16 + i * 256);
          end
          send(0, sa, sbv, sc, '0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready", W'(in_ready), '0);
      end
    join

    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", W'(sb_q.size()), '0);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qadd_pipe.md
Name: qadd_pipe

Overview:
- Parametrised, pipelined sign-magnitude fixed-point adder/subtractor with LANES independent lanes sharing one valid/ready stream.
- Successor to the combinational Q-format adder, used in p-bit weighted-sum datapaths.
- Adds a subtract mode, 2-stage registered pipeline with backpressure, per-lane sticky overflow and negative-zero normalisation.

Parameters:
- Q, 15, fractional bit count (binary point position); documentation and checks only; must satisfy Q < N-1.
- N, 32, word width: bit N-1 = sign, bits N-2:0 = magnitude.
- LANES, 1, number of parallel lanes; lane k occupies bits [k*N +: N] of packed buses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept input this cycle.
- op  in  1  0: c = a + b; 1: c = a - b (sign of b inverted); applies to all lanes.
- a  in  LANES*N  operand A, sign-magnitude per lane.
- b  in  LANES*N  operand B, sign-magnitude per lane.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- c  out  LANES*N  result, sign-magnitude per lane.
- ovr  out  LANES  per-lane overflow for the current result, qualified by out_valid.
- ovr_sticky  out  LANES  per-lane OR of ovr over all transferred results since last clear.
- clr_sticky  in  1  clears ovr_sticky next edge.

Behaviour:
- Single clock domain, synchronous active-high reset.
- Reset values: in_ready=1 after reset deasserts; out_valid=0, c=0, ovr=0, ovr_sticky=0; all stage valids 0. Reset mid-operation discards all in-flight data; no result is emitted for it.
- Stage 1 (S1) registers a, b with effective sign sb = b[N-1] XOR op. Stage 2 (S2) registers result, ovr. Latency: 2 cycles from input transfer (in_valid & in_ready) to out_valid.
- Flow control: S2 loads when S1 valid and (S2 empty or out_ready). S1 loads on input transfer. in_ready = !S1_valid | S2 loads this cycle. Back-to-back throughput 1 per cycle when out_ready=1.
- Holding: while out_valid=1 and out_ready=0, c/ovr are stable. in_ready is combinational on out_ready. No result is lost or duplicated. Order is preserved.
- Arithmetic per lane: ma = a[N-2:0], mb = b[N-2:0].
  - Same sign (a[N-1]==sb): sum = ma + mb, computed N bits wide. ovr = sum[N-1]. Magnitude = sum[N-2:0] (wraps). Sign = a[N-1].
  - Opposite sign, ma >= mb: magnitude = ma - mb, sign = a[N-1]. Otherwise magnitude = mb - ma, sign = sb. ovr = 0.
  - Normalisation: any zero result magnitude forces sign 0 (no negative zero output, including -0 + -0 and wrapped overflow to 0).
  - Inputs with -0 are accepted and treated as magnitude 0.
- ovr_sticky[k] sets on an output transfer (out_valid & out_ready) with ovr[k]=1.
  - clr_sticky clears it. If clr_sticky and a setting transfer occur in the same cycle, set wins.
- Lanes are fully independent. op and handshakes are shared.

Optional Feature:
- Macro QADD_SAT_EN.
- Defined: on same-sign overflow the magnitude saturates to all ones (2^(N-1)-1), keeping sign a[N-1]. ovr and ovr_sticky still assert.
- Undefined: magnitude wraps as above.

Test Plan:
- N=32, Q=15, op=0, a=0x00008000 (1.0), b=0x00014000 (2.5) -> c=0x0001C000, ovr=0, out_valid exactly 2 cycles after transfer.
- op=1, a=0x00008000, b=0x00014000 -> c=0x8000C000 (-1.5). op=1, a=b=0x00004000 -> c=0x00000000.
- op=0, a=0x7FFFFFFF, b=0x00000001 -> ovr=1. Without QADD_SAT_EN: c=0x00000000. With QADD_SAT_EN: c=0x7FFFFFFF. ovr_sticky=1 after transfer; clr_sticky pulse -> 0 next cycle.
- a=0x80000000, b=0x00000000 -> c=0x00000000. a=0x80000001, b=0x80000002 -> c=0x80000003.
- LANES=4 with lane values 1, 2, 3, 4 streamed 6 back-to-back; out_ready held 0 for 5 cycles.
  - in_ready drops after 2 accepted items. Results emerge in order, none lost or duplicated, c stable while stalled.
- rst asserted 1 cycle while out_valid=1 and S1 full -> next cycle out_valid=0, ovr_sticky=0, in_ready=1; no stale results afterwards.
